// File: rtl/assignment6_part1_if.sv
// assignment6_part1_if: byte-stream input and marker result bundle for the marker detector
// character/enable_character: one byte consumed per enabled clock; result: count at first marker end
interface assignment6_part1_if #(
  parameter int CNT_W = 16
);
  logic [7:0] character;
  logic enable_character;
  logic [CNT_W-1:0] result;
  modport master(output character, enable_character, input result);
  modport slave(input character, enable_character, output result);
endinterface

// File: rtl/assignment6_part1.sv
// assignment6_part1: streaming start-of-packet marker detector
// clk, rst (sync, active-high); bus.character/bus.enable_character in, bus.result out (registered)
module assignment6_part1 #(
  parameter int MARKER_LEN = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  assignment6_part1_if.slave bus
);
  logic [MARKER_LEN-2:0][7:0] win;
  logic [MARKER_LEN-1:0][7:0] cand;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic found;
  logic distinct;
  // cand[0] is the incoming byte, cand[k] the k-th most recent previous byte
  assign cand = {win, bus.character};
  assign count_n = &count ? count : count + 1'b1;
  always_comb begin
    distinct = 1'b1;
    for (int i = 0; i < MARKER_LEN; i++)
      for (int j = i + 1; j < MARKER_LEN; j++)
        distinct = distinct & (cand[i] != cand[j]);
  end
  // the count gate keeps the zeroed window from ever taking part in a match
  always_ff @(posedge clk)
    if (rst) begin
      win <= '0;
      count <= '0;
      found <= 1'b0;
      bus.result <= '0;
    end else if (bus.enable_character && !found) begin
      win <= cand[MARKER_LEN-2:0];
      count <= count_n;
      if (count_n >= CNT_W'(MARKER_LEN) && distinct) begin
        found <= 1'b1;
        bus.result <= count_n;
      end
    end
endmodule

// File: tb/tb_assignment6_part1.sv
// tb_assignment6_part1: directed vector bench for the marker detector
module tb_assignment6_part1;
  typedef struct {
    string s;
    int exp;
  } vec_t;
  logic clk;
  logic rst;
  int errors;
  int checks;
  vec_t vecs[7];
  assignment6_part1_if #(.CNT_W(16)) bus();
  assignment6_part1 #(.MARKER_LEN(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] c);
    bus.character = c;
    bus.enable_character = 1'b1;
    @(negedge clk);
    bus.enable_character = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    vecs[0] = '{"mjqjpqmgbljsphdztnvjfqwrcgsmlb\n", 7};
    vecs[1] = '{"bvwbjplbgvbhsrlpgdmjqwftvncz", 5};
    vecs[2] = '{"nppdvjthqldpwncqrgwj", 6};
    vecs[3] = '{"zcfzfwzzqfrljwzlrfnpqdbhtmscgvjw", 11};
    vecs[4] = '{"aaaaaaaa", 0};
    vecs[5] = '{"abc", 0};
    vecs[6] = '{"abcd", 4};
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.enable_character = 1'b0;
    bus.character = 8'h00;
    @(negedge clk);
    do_reset();
    check("reset_state", int'(bus.result), 0);
    for (int k = 0; k < 7; k++) begin
      do_reset();
      for (int i = 0; i < vecs[k].s.len(); i++) begin
        send(vecs[k].s[i]);
        check($sformatf("vec%0d_char%0d", k, i + 1), int'(bus.result),
              (vecs[k].exp != 0 && i + 1 >= vecs[k].exp) ? vecs[k].exp : 0);
      end
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_final", k), int'(bus.result), vecs[k].exp);
    end
    // zero bytes are real data once received
    do_reset();
    send(8'h00);
    send(8'h01);
    send(8'h02);
    check("zero_bytes_3", int'(bus.result), 0);
    send(8'h03);
    check("zero_bytes_4", int'(bus.result), 4);
    // idle gaps between characters add no count
    do_reset();
    begin
      string s;
      s = "mjqjpqm";
      for (int i = 0; i < s.len(); i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(s[i]);
        if (i == 5) check("idle_before", int'(bus.result), 0);
      end
    end
    repeat (2) @(negedge clk);
    check("idle_gaps", int'(bus.result), 7);
    // reset mid-stream, with enable held high during reset
    do_reset();
    send("a");
    send("a");
    send("b");
    rst = 1'b1;
    bus.character = "x";
    bus.enable_character = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.enable_character = 1'b0;
    send("b");
    send("c");
    send("d");
    check("rst_mid_before", int'(bus.result), 0);
    send("e");
    check("rst_mid_found", int'(bus.result), 4);
    do_reset();
    check("rst_after_found", int'(bus.result), 0);
    // counter saturates instead of wrapping
    for (int i = 0; i < 65540; i++) send("a");
    check("sat_before", int'(bus.result), 0);
    send("b");
    send("c");
    send("d");
    check("sat_result", int'(bus.result), 65535);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
